vending_customer: RTL
=====================

# vending_customer

Customer-side driver for the vending machine coin/button/beverage interface; the opposite end of the interface the vending machine checker observes. It accepts a purchase request, inserts coins and presses the selection button. It then waits for delivery, keeps the interface quiet for the post-delivery window, and reports the delivered beverage, the change received and an error code. It sits in the bench/system top, wired directly to the vending machine's coin_in, button_in, beverage_out and change_out.

## Interface
- N, 3, post-delivery quiet window in cycles (coin_in and button_in held 0)
- COIN_GAP, 1, idle cycles (coin_in = 0) after every inserted coin; ≥ 1
- TIMEOUT, 16, max cycles waited for beverage_out after the button press; ≥ 1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  purchase request valid
- req_ready  out  1  high only in IDLE
- req_sel  in  2  1 = beverage 1 (price 30), 2 = beverage 2 (price 50)
- req_coin  in  8  0 = pay exact (greedy); else the single denomination used for every coin
- coin_in  out  8  coin to machine; 0 = no coin; legal values 10/20/50/100/200
- button_in  out  2  selection button; 0 = none; equals req_sel for exactly one cycle
- beverage_out  in  2  delivered beverage, nonzero = delivery
- change_out  in  8  change from machine, nonzero = change presented
- rsp_valid  out  1  one-cycle response pulse
- rsp_bev  out  2  beverage code captured
- rsp_paid  out  8  total coin value inserted
- rsp_change  out  8  change accumulated (saturating at 255)
- rsp_err  out  3  0 ok, 1 bad request, 2 timeout, 3 wrong beverage, 4 change mismatch

## Operation
- States: IDLE, INSERT, GAP, PRESS, WAIT_BEV, QUIET, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture req_sel and req_coin, set price = 30/50, clear paid and change.
  - If req_sel is not 1 or 2, or req_coin is not in {0,10,20,50,100,200}, go to RESP with err 1, paid 0 and no interface activity.
  - Otherwise go to INSERT.
- INSERT (1 cycle):
  - Drive coin_in = coin and add coin to paid.
  - Greedy mode: coin is the largest of 200/100/50/20/10 that is ≤ price − paid.
  - Fixed mode: coin = req_coin.
  - Go to GAP.
- GAP: hold coin_in = 0 for COIN_GAP cycles. Then go to INSERT if paid < price, else PRESS.
- PRESS (1 cycle): button_in = req_sel, then go to WAIT_BEV with the timer cleared.
- WAIT_BEV:
  - On the first cycle with beverage_out ≠ 0, capture rsp_bev and add change_out to change, then go to QUIET.
  - If TIMEOUT cycles pass with no delivery, go to RESP with err 2, skipping QUIET.
- QUIET (N cycles):
  - coin_in = button_in = 0.
  - Each cycle, add any nonzero change_out to change (saturating).
  - Then go to RESP.
- RESP (1 cycle): rsp_valid = 1, then IDLE. Error priority is timeout > wrong beverage (rsp_bev ≠ req_sel) > change mismatch (change ≠ paid − price) > ok.
- Arithmetic: paid ≤ 200, so 8 bits never overflow. Expected change is paid − price, unsigned and never negative.

## Timing
- Reset (asynchronous, any state): state IDLE; coin_in, button_in, rsp_* all 0; req_ready = 1 once rst is released.
- All outputs are registered. coin_in and button_in are never both nonzero in the same cycle.
- Request accepted at edge 0 → first coin on coin_in at cycle 1.
- With COIN_GAP = g and k coins, the button is driven at cycle 1 + k(1+g).
- A delivery in the same cycle as PRESS is ignored. Sampling starts the cycle after PRESS.
- The rsp_valid cycle always has req_ready = 0. A request held during RESP is accepted in the following IDLE cycle.
- rsp_* hold their values until the next response. Only rsp_valid pulses.

## Test plan
- Reset mid-INSERT (coin_in = 20) → coin_in = 0 immediately (asynchronous); req_ready = 1 after release; no rsp_valid.
- sel = 1, coin = 0, COIN_GAP = 1, machine delivers 1 with change 0 → coin 20 @c1, 10 @c3, button 1 @c5; rsp paid 30, change 0, err 0.
- sel = 2, coin = 200, machine returns change 150 on the delivery cycle → single coin 200, button 2 @c3; rsp paid 200, change 150, err 0; inputs 0 for N cycles after delivery.
- sel = 2, coin = 10 → five 10 coins; change split as 0 on delivery then 0 → err 0. Variant with 100 coins and change split 30 + 20 during QUIET → change 50, err 0.
- sel = 1, coin = 0, no delivery → rsp_valid TIMEOUT+1 cycles after the press, err 2, bev 0.
- sel = 3 or coin = 30 → no coin or button activity, rsp next cycle with err 1. Separately, sel = 1 with delivery of 2 → err 3; sel = 1, coin = 50, change 10 → err 4.

Source files
------------

// File: rtl/vending_customer.sv
// -----------------------------------------------------------------------------
// vending_customer
//   Customer-side driver for the vending machine coin/button/beverage interface.
//   Takes one purchase request, feeds coins into the machine (greedy exact
//   payment or repeated fixed denomination), presses the selection button,
//   waits for the beverage, keeps the interface quiet for a short window while
//   collecting change, then reports beverage, amount paid, change and an error.
//
// Parameters
//   N         post-delivery quiet window in cycles
//   COIN_GAP  idle cycles after every inserted coin (>= 1)
//   TIMEOUT   cycles waited for a delivery after the button press (>= 1)
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-low reset
//   i_req_valid      purchase request valid
//   o_req_ready      high only while idle
//   i_req_sel  [1:0] 1 = beverage 1 (30), 2 = beverage 2 (50)
//   i_req_coin [7:0] 0 = greedy exact payment, else denomination for every coin
//   o_coin_in  [7:0] coin to machine, 0 = none
//   o_button_in[1:0] selection button, 0 = none
//   i_beverage_out   delivered beverage, nonzero = delivery
//   i_change_out     change from machine, nonzero = change presented
//   o_rsp_valid      one-cycle response pulse
//   o_rsp_bev        captured beverage code
//   o_rsp_paid       total coin value inserted
//   o_rsp_change     change accumulated (saturating)
//   o_rsp_err  [2:0] 0 ok, 1 bad request, 2 timeout, 3 wrong beverage,
//                    4 change mismatch
// -----------------------------------------------------------------------------
module vending_customer #(
    parameter int N        = 3,
    parameter int COIN_GAP = 1,
    parameter int TIMEOUT  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [1:0] i_req_sel,
    input  logic [7:0] i_req_coin,
    output logic [7:0] o_coin_in,
    output logic [1:0] o_button_in,
    input  logic [1:0] i_beverage_out,
    input  logic [7:0] i_change_out,
    output logic       o_rsp_valid,
    output logic [1:0] o_rsp_bev,
    output logic [7:0] o_rsp_paid,
    output logic [7:0] o_rsp_change,
    output logic [2:0] o_rsp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INSERT,
        S_GAP,
        S_PRESS,
        S_WAIT_BEV,
        S_QUIET,
        S_RESP
    } state_t;

    // One shared down-the-line counter serves GAP, WAIT_BEV and QUIET.
    localparam int MAX_GT = (TIMEOUT > COIN_GAP) ? TIMEOUT : COIN_GAP;
    localparam int MAXC   = (MAX_GT > N) ? MAX_GT : N;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] QUIET_LAST = CW'((N > 0) ? N - 1 : 0);

    localparam logic [2:0] ERR_OK     = 3'd0;
    localparam logic [2:0] ERR_REQ    = 3'd1;
    localparam logic [2:0] ERR_TMO    = 3'd2;
    localparam logic [2:0] ERR_BEV    = 3'd3;
    localparam logic [2:0] ERR_CHANGE = 3'd4;

    // Largest legal coin not exceeding the remaining amount.
    function automatic logic [7:0] f_greedy(input logic [7:0] rem);
        if (rem >= 8'd200)     return 8'd200;
        else if (rem >= 8'd100) return 8'd100;
        else if (rem >= 8'd50)  return 8'd50;
        else if (rem >= 8'd20)  return 8'd20;
        else if (rem >= 8'd10)  return 8'd10;
        else                    return 8'd0;
    endfunction

    function automatic logic f_coin_ok(input logic [7:0] c);
        return (c == 8'd0)  || (c == 8'd10)  || (c == 8'd20) ||
               (c == 8'd50) || (c == 8'd100) || (c == 8'd200);
    endfunction

    // ---------------------------------------------------------------- state
    state_t        r_state;
    logic [1:0]    r_sel;
    logic [7:0]    r_coin_req;
    logic [7:0]    r_price;
    logic [7:0]    r_paid;
    logic [7:0]    r_change;
    logic [1:0]    r_bev;
    logic [CW-1:0] r_cnt;

    // registered outputs
    logic          r_req_ready;
    logic [7:0]    r_coin_in;
    logic [1:0]    r_button_in;
    logic          r_rsp_valid;
    logic [1:0]    r_rsp_bev;
    logic [7:0]    r_rsp_paid;
    logic [7:0]    r_rsp_change;
    logic [2:0]    r_rsp_err;

    // ---------------------------------------------------------------- next
    state_t        w_state;
    logic [1:0]    w_sel;
    logic [7:0]    w_coin_req;
    logic [7:0]    w_price;
    logic [7:0]    w_paid;
    logic [7:0]    w_change;
    logic [1:0]    w_bev;
    logic [CW-1:0] w_cnt;
    logic          w_bad_req;
    logic          w_timeout;
    logic [7:0]    w_ins_coin;

    logic          w_req_ready;
    logic [7:0]    w_coin_in;
    logic [1:0]    w_button_in;
    logic          w_rsp_valid;
    logic [1:0]    w_rsp_bev;
    logic [7:0]    w_rsp_paid;
    logic [7:0]    w_rsp_change;
    logic [2:0]    w_rsp_err;

    // Saturating change accumulation; adding zero is a no-op, so this can be
    // applied unconditionally in QUIET.
    logic [8:0] w_chg_sum;
    logic [7:0] w_chg_sat;
    assign w_chg_sum = {1'b0, r_change} + {1'b0, i_change_out};
    assign w_chg_sat = w_chg_sum[8] ? 8'hFF : w_chg_sum[7:0];

    always_comb begin
        w_state    = r_state;
        w_sel      = r_sel;
        w_coin_req = r_coin_req;
        w_price    = r_price;
        w_paid     = r_paid;
        w_change   = r_change;
        w_bev      = r_bev;
        w_cnt      = r_cnt;
        w_bad_req  = 1'b0;
        w_timeout  = 1'b0;
        w_ins_coin = 8'd0;

        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_sel      = i_req_sel;
                    w_coin_req = i_req_coin;
                    w_price    = (i_req_sel == 2'd2) ? 8'd50 : 8'd30;
                    w_paid     = 8'd0;
                    w_change   = 8'd0;
                    w_bev      = 2'd0;
                    if (!((i_req_sel == 2'd1) || (i_req_sel == 2'd2)) ||
                        !f_coin_ok(i_req_coin)) begin
                        w_bad_req = 1'b1;
                        w_state   = S_RESP;
                    end else begin
                        w_state = S_INSERT;
                    end
                end
            end
            S_INSERT: begin
                w_state = S_GAP;
                w_cnt   = '0;
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state = (r_paid < r_price) ? S_INSERT : S_PRESS;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_PRESS: begin
                w_state = S_WAIT_BEV;
                w_cnt   = '0;
            end
            S_WAIT_BEV: begin
                if (i_beverage_out != 2'd0) begin
                    w_bev    = i_beverage_out;
                    w_change = w_chg_sat;
                    w_cnt    = '0;
                    w_state  = (N > 0) ? S_QUIET : S_RESP;
                end else if (r_cnt == TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_state   = S_RESP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_QUIET: begin
                w_change = w_chg_sat;
                if (r_cnt == QUIET_LAST) begin
                    w_state = S_RESP;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Coin choice uses the next-cycle view of price/paid/mode so the first
        // coin can be issued straight out of IDLE.
        if (w_state == S_INSERT) begin
            w_ins_coin = (w_coin_req == 8'd0) ? f_greedy(w_price - w_paid)
                                              : w_coin_req;
            w_paid     = w_paid + w_ins_coin;
        end

        // Outputs are a function of the state being entered, then registered.
        w_req_ready  = (w_state == S_IDLE);
        w_coin_in    = (w_state == S_INSERT) ? w_ins_coin : 8'd0;
        w_button_in  = (w_state == S_PRESS) ? w_sel : 2'd0;
        w_rsp_valid  = (w_state == S_RESP);
        w_rsp_bev    = r_rsp_bev;
        w_rsp_paid   = r_rsp_paid;
        w_rsp_change = r_rsp_change;
        w_rsp_err    = r_rsp_err;

        if (w_state == S_RESP) begin
            w_rsp_bev    = w_bev;
            w_rsp_paid   = w_paid;
            w_rsp_change = w_change;
            if (w_bad_req)                         w_rsp_err = ERR_REQ;
            else if (w_timeout)                    w_rsp_err = ERR_TMO;
            else if (w_bev != w_sel)               w_rsp_err = ERR_BEV;
            else if (w_change != (w_paid - w_price)) w_rsp_err = ERR_CHANGE;
            else                                   w_rsp_err = ERR_OK;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_sel        <= 2'd0;
            r_coin_req   <= 8'd0;
            r_price      <= 8'd0;
            r_paid       <= 8'd0;
            r_change     <= 8'd0;
            r_bev        <= 2'd0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_coin_in    <= 8'd0;
            r_button_in  <= 2'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_bev    <= 2'd0;
            r_rsp_paid   <= 8'd0;
            r_rsp_change <= 8'd0;
            r_rsp_err    <= 3'd0;
        end else begin
            r_state      <= w_state;
            r_sel        <= w_sel;
            r_coin_req   <= w_coin_req;
            r_price      <= w_price;
            r_paid       <= w_paid;
            r_change     <= w_change;
            r_bev        <= w_bev;
            r_cnt        <= w_cnt;
            r_req_ready  <= w_req_ready;
            r_coin_in    <= w_coin_in;
            r_button_in  <= w_button_in;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_bev    <= w_rsp_bev;
            r_rsp_paid   <= w_rsp_paid;
            r_rsp_change <= w_rsp_change;
            r_rsp_err    <= w_rsp_err;
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_coin_in    = r_coin_in;
    assign o_button_in  = r_button_in;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_bev    = r_rsp_bev;
    assign o_rsp_paid   = r_rsp_paid;
    assign o_rsp_change = r_rsp_change;
    assign o_rsp_err    = r_rsp_err;

endmodule
